// File: rtl/nf_10g_stats_pkg.sv
// rtl/nf_10g_stats_pkg.sv - shared constants and helpers for the 10G statistics collector
//
// Purpose: counter indices, statistics-vector field positions and vector widths shared by
//          the collector top level and its per-counter sub-module.
// Ports:   none (package).

package nf_10g_stats_pkg;

    // Counter indices within one port.
    localparam int RX_GOOD   = 0;
    localparam int RX_BAD    = 1;
    localparam int RX_BYTES  = 2;
    localparam int TX_FRAMES = 3;
    localparam int TX_BYTES  = 4;
    localparam int NUM_CNT   = 5;

    // Field positions inside one port's statistics word.
    localparam int RX_GOOD_BIT = 0;
    localparam int RX_BAD_BIT  = 1;
    localparam int TX_OK_BIT   = 0;
    localparam int LEN_LSB     = 5;
    localparam int LEN_MSB     = 19;

    // Per-port statistics word widths.
    localparam int RX_VEC_W = 30;
    localparam int TX_VEC_W = 26;

    // True when (port, sel) names an existing counter.
    function automatic logic idx_in_range(input logic [2:0] port,
                                          input logic [2:0] sel,
                                          input int         num_ports);
        return (int'(port) < num_ports) && (int'(sel) < NUM_CNT);
    endfunction

endpackage

// File: rtl/nf_10g_stat_counter.sv
// rtl/nf_10g_stat_counter.sv - one statistics counter with wrap/saturate and overflow pulse
//
// Purpose: a single unsigned accumulator. Each cycle it may be cleared, reloaded with the
//          current increment (clear-on-read), or advanced by inc_val.
// Ports:
//   clk      in   clock
//   reset    in   synchronous, active-high
//   clr      in   zero the counter; highest priority, the increment is discarded
//   rd_clr   in   counter was just read with clear-on-read: reload with this cycle's increment
//   inc_en   in   add inc_val this cycle
//   inc_val  in   increment amount
//   count    out  current value
//   ovf      out  combinational pulse: this cycle's accepted increment carried out of the top bit

module nf_10g_stat_counter
    import nf_10g_stats_pkg::*;
#(
    parameter int C_CNT_WIDTH = 48,
    parameter int C_SATURATE  = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clr,
    input  logic                   rd_clr,
    input  logic                   inc_en,
    input  logic [C_CNT_WIDTH-1:0] inc_val,
    output logic [C_CNT_WIDTH-1:0] count,
    output logic                   ovf
);

    logic [C_CNT_WIDTH:0] sum;
    logic                 carry;

    assign sum   = {1'b0, count} + {1'b0, inc_val};
    assign carry = sum[C_CNT_WIDTH];

    // A reload (clr or rd_clr) discards the old value, so no carry can be lost there.
    // In saturate mode a counter already at all-ones carries again on any non-zero
    // increment, which keeps re-asserting the sticky flag upstream.
    assign ovf = inc_en && carry && !clr && !rd_clr;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (rd_clr) begin
            count <= inc_en ? inc_val : '0;
        end else if (inc_en) begin
            if (carry && (C_SATURATE != 0)) begin
                count <= '1;
            end else begin
                count <= sum[C_CNT_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/nf_10g_stats_collector.sv
// rtl/nf_10g_stats_collector.sv - multi-port MAC statistics accumulator with indexed read port
//
// Purpose: keeps RX_GOOD, RX_BAD, RX_BYTES, TX_FRAMES and TX_BYTES per MAC port, fed by
//          per-port rx/tx statistics strobes, readable through a 1-cycle-latency read port.
// Ports:
//   core_clk        in   sole clock
//   reset           in   synchronous, active-high
//   rx_stat_valid   in   per-port rx statistics strobe
//   rx_stat_vector  in   per-port rx word, port p at [30p+29:30p]
//   tx_stat_valid   in   per-port tx statistics strobe
//   tx_stat_vector  in   per-port tx word, port p at [26p+25:26p]
//   clear_all       in   zero every counter and overflow flag (beats increments and reads)
//   rd_req          in   one-cycle read request
//   rd_port         in   port index
//   rd_sel          in   counter index
//   rd_ack          out  read response strobe, one cycle after rd_req
//   rd_data         out  counter value as it was before the request edge's update
//   rd_err          out  set with rd_ack when (rd_port, rd_sel) names no counter
//   ovf_flags       out  sticky per-port overflow flags

module nf_10g_stats_collector
    import nf_10g_stats_pkg::*;
#(
    parameter int C_NUM_PORTS     = 4,
    parameter int C_CNT_WIDTH     = 48,
    parameter int C_SATURATE      = 0,
    parameter int C_CLEAR_ON_READ = 0
) (
    input  logic                            core_clk,
    input  logic                            reset,
    input  logic [C_NUM_PORTS-1:0]          rx_stat_valid,
    input  logic [RX_VEC_W*C_NUM_PORTS-1:0] rx_stat_vector,
    input  logic [C_NUM_PORTS-1:0]          tx_stat_valid,
    input  logic [TX_VEC_W*C_NUM_PORTS-1:0] tx_stat_vector,
    input  logic                            clear_all,
    input  logic                            rd_req,
    input  logic [2:0]                      rd_port,
    input  logic [2:0]                      rd_sel,
    output logic                            rd_ack,
    output logic [C_CNT_WIDTH-1:0]          rd_data,
    output logic                            rd_err,
    output logic [C_NUM_PORTS-1:0]          ovf_flags
);

    localparam int NUM_TOTAL = C_NUM_PORTS * NUM_CNT;

    logic [C_CNT_WIDTH-1:0] cnt_val [NUM_TOTAL];
    logic [C_NUM_PORTS-1:0] port_ovf;
    logic                   rd_ok;
    logic                   cor_fire;
    logic [C_CNT_WIDTH-1:0] rd_mux;

    assign rd_ok = idx_in_range(rd_port, rd_sel, C_NUM_PORTS);

    // Only a valid read may clear its counter; clear_all still wins inside the counter.
    assign cor_fire = (C_CLEAR_ON_READ != 0) && rd_req && rd_ok;

    for (genvar p = 0; p < C_NUM_PORTS; p++) begin : g_port
        logic [RX_VEC_W-1:0]    rx_word;
        logic [TX_VEC_W-1:0]    tx_word;
        logic                   rx_good;
        logic                   rx_bad;
        logic                   tx_ok;
        logic [C_CNT_WIDTH-1:0] rx_len;
        logic [C_CNT_WIDTH-1:0] tx_len;
        logic [NUM_CNT-1:0]     inc_en;
        logic [C_CNT_WIDTH-1:0] inc_val [NUM_CNT];
        logic [NUM_CNT-1:0]     cnt_ovf;
        logic                   unused_fields;

        assign rx_word = rx_stat_vector[RX_VEC_W*p +: RX_VEC_W];
        assign tx_word = tx_stat_vector[TX_VEC_W*p +: TX_VEC_W];

        assign rx_good = rx_stat_valid[p] && rx_word[RX_GOOD_BIT];
        assign rx_bad  = rx_stat_valid[p] && rx_word[RX_BAD_BIT];
        assign tx_ok   = tx_stat_valid[p] && tx_word[TX_OK_BIT];

        assign rx_len = C_CNT_WIDTH'(rx_word[LEN_MSB:LEN_LSB]);
        assign tx_len = C_CNT_WIDTH'(tx_word[LEN_MSB:LEN_LSB]);

        // Reserved status bits carry no meaning for these counters.
        assign unused_fields = ^{rx_word[LEN_LSB-1:RX_BAD_BIT+1], rx_word[RX_VEC_W-1:LEN_MSB+1],
                                 tx_word[LEN_LSB-1:TX_OK_BIT+1],  tx_word[TX_VEC_W-1:LEN_MSB+1]};

        assign inc_en[RX_GOOD]   = rx_good;
        assign inc_en[RX_BAD]    = rx_bad;
        assign inc_en[RX_BYTES]  = rx_good;
        assign inc_en[TX_FRAMES] = tx_ok;
        assign inc_en[TX_BYTES]  = tx_ok;

        assign inc_val[RX_GOOD]   = C_CNT_WIDTH'(1);
        assign inc_val[RX_BAD]    = C_CNT_WIDTH'(1);
        assign inc_val[RX_BYTES]  = rx_len;
        assign inc_val[TX_FRAMES] = C_CNT_WIDTH'(1);
        assign inc_val[TX_BYTES]  = tx_len;

        for (genvar c = 0; c < NUM_CNT; c++) begin : g_cnt
            logic rd_clr;

            assign rd_clr = cor_fire && (int'(rd_port) == p) && (int'(rd_sel) == c);

            nf_10g_stat_counter #(
                .C_CNT_WIDTH (C_CNT_WIDTH),
                .C_SATURATE  (C_SATURATE)
            ) u_cnt (
                .clk     (core_clk),
                .reset   (reset),
                .clr     (clear_all),
                .rd_clr  (rd_clr),
                .inc_en  (inc_en[c]),
                .inc_val (inc_val[c]),
                .count   (cnt_val[p*NUM_CNT+c]),
                .ovf     (cnt_ovf[c])
            );
        end

        assign port_ovf[p] = |cnt_ovf;
    end

    // Read mux over the pre-update counter values; an index matching no counter yields 0.
    always_comb begin
        rd_mux = '0;
        for (int p = 0; p < C_NUM_PORTS; p++) begin
            for (int c = 0; c < NUM_CNT; c++) begin
                if ((int'(rd_port) == p) && (int'(rd_sel) == c)) begin
                    rd_mux = cnt_val[p*NUM_CNT+c];
                end
            end
        end
    end

    // Response registers: a reset in the request's cycle drops the ack.
    always_ff @(posedge core_clk) begin
        if (reset) begin
            rd_ack  <= 1'b0;
            rd_data <= '0;
            rd_err  <= 1'b0;
        end else begin
            rd_ack <= rd_req;
            if (rd_req) begin
                rd_data <= rd_ok ? rd_mux : '0;
                rd_err  <= !rd_ok;
            end else begin
                rd_data <= '0;
                rd_err  <= 1'b0;
            end
        end
    end

    always_ff @(posedge core_clk) begin
        if (reset || clear_all) begin
            ovf_flags <= '0;
        end else begin
            ovf_flags <= ovf_flags | port_ovf;
        end
    end

endmodule

// File: tb/tb_nf_10g_stats_collector.sv
// tb/tb_nf_10g_stats_collector.sv - scoreboard bench for the 10G statistics collector

module tb_nf_10g_stats_collector;

    typedef struct {
        logic [63:0] data;
        logic        err;
        string       name;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   rx_valid;
    logic [119:0] rx_vec;
    logic [3:0]   tx_valid;
    logic [103:0] tx_vec;
    logic         clear_all;
    logic         rd_req;
    logic [2:0]   rd_port;
    logic [2:0]   rd_sel;

    logic         rd_ack_w [4];
    logic         rd_err_w [4];
    logic [63:0]  rd_data_w [4];
    logic [3:0]   ovf_w [4];

    logic [47:0]  d0_data;
    logic [15:0]  d1_data;
    logic [15:0]  d2_data;
    logic [47:0]  d3_data;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t q3[$];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // d0: default; d1: 16-bit wrap; d2: 16-bit saturate; d3: clear-on-read.
    nf_10g_stats_collector #(.C_NUM_PORTS(4), .C_CNT_WIDTH(48), .C_SATURATE(0), .C_CLEAR_ON_READ(0)) d0 (
        .core_clk(clk), .reset(reset), .rx_stat_valid(rx_valid), .rx_stat_vector(rx_vec),
        .tx_stat_valid(tx_valid), .tx_stat_vector(tx_vec), .clear_all(clear_all),
        .rd_req(rd_req), .rd_port(rd_port), .rd_sel(rd_sel), .rd_ack(rd_ack_w[0]),
        .rd_data(d0_data), .rd_err(rd_err_w[0]), .ovf_flags(ovf_w[0]));

    nf_10g_stats_collector #(.C_NUM_PORTS(4), .C_CNT_WIDTH(16), .C_SATURATE(0), .C_CLEAR_ON_READ(0)) d1 (
        .core_clk(clk), .reset(reset), .rx_stat_valid(rx_valid), .rx_stat_vector(rx_vec),
        .tx_stat_valid(tx_valid), .tx_stat_vector(tx_vec), .clear_all(clear_all),
        .rd_req(rd_req), .rd_port(rd_port), .rd_sel(rd_sel), .rd_ack(rd_ack_w[1]),
        .rd_data(d1_data), .rd_err(rd_err_w[1]), .ovf_flags(ovf_w[1]));

    nf_10g_stats_collector #(.C_NUM_PORTS(4), .C_CNT_WIDTH(16), .C_SATURATE(1), .C_CLEAR_ON_READ(0)) d2 (
        .core_clk(clk), .reset(reset), .rx_stat_valid(rx_valid), .rx_stat_vector(rx_vec),
        .tx_stat_valid(tx_valid), .tx_stat_vector(tx_vec), .clear_all(clear_all),
        .rd_req(rd_req), .rd_port(rd_port), .rd_sel(rd_sel), .rd_ack(rd_ack_w[2]),
        .rd_data(d2_data), .rd_err(rd_err_w[2]), .ovf_flags(ovf_w[2]));

    nf_10g_stats_collector #(.C_NUM_PORTS(4), .C_CNT_WIDTH(48), .C_SATURATE(0), .C_CLEAR_ON_READ(1)) d3 (
        .core_clk(clk), .reset(reset), .rx_stat_valid(rx_valid), .rx_stat_vector(rx_vec),
        .tx_stat_valid(tx_valid), .tx_stat_vector(tx_vec), .clear_all(clear_all),
        .rd_req(rd_req), .rd_port(rd_port), .rd_sel(rd_sel), .rd_ack(rd_ack_w[3]),
        .rd_data(d3_data), .rd_err(rd_err_w[3]), .ovf_flags(ovf_w[3]));

    assign rd_data_w[0] = 64'(d0_data);
    assign rd_data_w[1] = 64'(d1_data);
    assign rd_data_w[2] = 64'(d2_data);
    assign rd_data_w[3] = 64'(d3_data);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic push(input int k, input exp_t e);
        case (k)
            0: q0.push_back(e);
            1: q1.push_back(e);
            2: q2.push_back(e);
            default: q3.push_back(e);
        endcase
    endtask

    task automatic pop_check(input int k);
        exp_t e;
        int   n;
        case (k)
            0: n = q0.size();
            1: n = q1.size();
            2: n = q2.size();
            default: n = q3.size();
        endcase
        total++;
        if (n == 0) begin
            bad++;
            $display("FAIL unexpected_ack dut%0d data=%0d err=%0b", k, rd_data_w[k], rd_err_w[k]);
        end else begin
            case (k)
                0: e = q0.pop_front();
                1: e = q1.pop_front();
                2: e = q2.pop_front();
                default: e = q3.pop_front();
            endcase
            if (rd_data_w[k] !== e.data || rd_err_w[k] !== e.err) begin
                bad++;
                $display("FAIL %s dut%0d got data=%0d err=%0b want data=%0d err=%0b",
                         e.name, k, rd_data_w[k], rd_err_w[k], e.data, e.err);
            end
        end
    endtask

    // Monitor: one expected entry per acknowledged read, per DUT.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rd_ack_w[k] === 1'b1) pop_check(k);
        end
    end

    task automatic rd_set(input int p, input int s, input logic [63:0] e0, input logic [63:0] e1,
                          input logic [63:0] e2, input logic [63:0] e3, input logic err);
        exp_t e;
        e.err  = err;
        e.name = $sformatf("rd(%0d,%0d)", p, s);
        e.data = e0; push(0, e);
        e.data = e1; push(1, e);
        e.data = e2; push(2, e);
        e.data = e3; push(3, e);
        rd_req  = 1'b1;
        rd_port = 3'(p);
        rd_sel  = 3'(s);
    endtask

    task automatic rd(input int p, input int s, input logic [63:0] e0, input logic [63:0] e1,
                      input logic [63:0] e2, input logic [63:0] e3, input logic err);
        rd_set(p, s, e0, e1, e2, e3, err);
        tick();
        rd_req = 1'b0;
    endtask

    task automatic rd_all(input int p, input int s, input logic [63:0] v);
        rd(p, s, v, v, v, v, 1'b0);
    endtask

    // Reserved bits are driven high to show they are ignored.
    task automatic set_rx(input int p, input logic good, input logic badf, input int len);
        logic [29:0] w;
        w        = '1;
        w[0]     = good;
        w[1]     = badf;
        w[19:5]  = 15'(len);
        rx_vec[30*p +: 30] = w;
        rx_valid[p] = 1'b1;
    endtask

    task automatic set_tx(input int p, input int len);
        logic [25:0] w;
        w       = '1;
        w[19:5] = 15'(len);
        tx_vec[26*p +: 26] = w;
        tx_valid[p] = 1'b1;
    endtask

    task automatic chk_ovf(input logic [3:0] e0, input logic [3:0] e1,
                           input logic [3:0] e2, input logic [3:0] e3);
        chk("ovf_flags dut0", 64'(ovf_w[0]), 64'(e0));
        chk("ovf_flags dut1", 64'(ovf_w[1]), 64'(e1));
        chk("ovf_flags dut2", 64'(ovf_w[2]), 64'(e2));
        chk("ovf_flags dut3", 64'(ovf_w[3]), 64'(e3));
    endtask

    initial begin
        reset     = 1'b1;
        rx_valid  = '0;
        rx_vec    = '0;
        tx_valid  = '0;
        tx_vec    = '0;
        clear_all = 1'b0;
        rd_req    = 1'b0;
        rd_port   = '0;
        rd_sel    = '0;
        repeat (3) tick();

        for (int k = 0; k < 4; k++) begin
            chk($sformatf("reset rd_ack dut%0d", k),  64'(rd_ack_w[k]), 64'd0);
            chk($sformatf("reset rd_err dut%0d", k),  64'(rd_err_w[k]), 64'd0);
            chk($sformatf("reset rd_data dut%0d", k), rd_data_w[k], 64'd0);
        end
        chk_ovf(4'h0, 4'h0, 4'h0, 4'h0);
        reset = 1'b0;
        rd_all(0, 0, 0);

        // Three good rx frames of 64 bytes on port 0.
        set_rx(0, 1'b1, 1'b0, 64);
        repeat (3) tick();
        rx_valid = '0;
        rd_all(0, 0, 3);
        rd_all(0, 2, 192);

        // All ports transmit 1500-byte frames for 10 cycles; reads go back to back.
        for (int p = 0; p < 4; p++) set_tx(p, 1500);
        repeat (10) tick();
        tx_valid = '0;
        for (int p = 0; p < 4; p++) begin
            rd_all(p, 3, 10);
            rd_all(p, 4, 15000);
        end

        // Invalid indices, then counters are unchanged (d3 already cleared them by reading).
        rd(5, 0, 0, 0, 0, 0, 1'b1);
        rd(0, 7, 0, 0, 0, 0, 1'b1);
        rd(4, 2, 0, 0, 0, 0, 1'b1);
        rd(0, 0, 3, 3, 3, 0, 1'b0);
        rd(1, 3, 10, 10, 10, 0, 1'b0);
        repeat (3) tick();

        // A read issued in a reset cycle must not be acknowledged.
        reset   = 1'b1;
        rd_req  = 1'b1;
        rd_port = 3'd0;
        rd_sel  = 3'd0;
        tick();
        rd_req = 1'b0;
        tick();
        reset = 1'b0;

        // 44 x 1500 = 66000 bytes: wraps to 464 at 16 bits, clamps to 65535 when saturating.
        set_rx(0, 1'b1, 1'b0, 1500);
        repeat (44) tick();
        rx_valid = '0;
        rd_all(0, 0, 44);
        rd(0, 2, 66000, 464, 65535, 66000, 1'b0);
        chk_ovf(4'h0, 4'h1, 4'h1, 4'h0);
        set_rx(0, 1'b1, 1'b0, 1500);
        tick();
        rx_valid = '0;
        rd(0, 2, 67500, 1964, 65535, 1500, 1'b0);
        chk_ovf(4'h0, 4'h1, 4'h1, 4'h0);

        // Port 2: five good frames, then a read coinciding with a sixth; port 3: two bad frames.
        set_rx(2, 1'b1, 1'b0, 100);
        set_rx(3, 1'b0, 1'b1, 50);
        repeat (2) tick();
        rx_valid[3] = 1'b0;
        repeat (3) tick();
        rd_set(2, 0, 5, 5, 5, 5, 1'b0);
        tick();
        rx_valid = '0;
        rd_req   = 1'b0;
        rd(2, 0, 6, 6, 6, 1, 1'b0);
        rd_all(3, 1, 2);
        rd_all(3, 2, 0);
        rd_all(3, 0, 0);

        // Nine good frames on port 1, then clear_all together with a tenth frame and a read.
        set_rx(1, 1'b1, 1'b0, 20);
        repeat (9) tick();
        clear_all = 1'b1;
        rd_set(1, 0, 9, 9, 9, 9, 1'b0);
        tick();
        clear_all = 1'b0;
        rx_valid  = '0;
        rd_req    = 1'b0;
        rd_all(1, 0, 0);
        rd_all(1, 2, 0);
        rd_all(0, 2, 0);
        rd_all(2, 0, 0);
        chk_ovf(4'h0, 4'h0, 4'h0, 4'h0);

        repeat (4) tick();
        chk("pending dut0", 64'(q0.size()), 64'd0);
        chk("pending dut1", 64'(q1.size()), 64'd0);
        chk("pending dut2", 64'(q2.size()), 64'd0);
        chk("pending dut3", 64'(q3.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
